// File: rtl/hack_vga_scanner_if.sv
// Port-B read bus between the VGA scanner and the Hack screen buffer.
// The scanner (master) presents a registered word address; the buffer
// (slave) returns the addressed 16-bit word during the cycle that follows
// the counter state that produced the address. The scanner only reads, so
// there is no valid/ready pair: the fetch schedule is fixed by the raster.
interface hack_vga_scanner_if;
  logic [12:0] vga_addr;
  logic [15:0] vga_out;

  modport master (output vga_addr, input vga_out);
  modport slave  (input vga_addr, output vga_out);
endinterface

// File: rtl/hack_vga_scanner.sv
// 640x480@60 VGA scanner for the 512x256 Hack screen, centred in the active
// area with a fixed border colour. Three-stage pipeline: counters/address,
// word fetch/hold, registered pixel+sync outputs (2-cycle latency).
// Optional macro HACK_VGA_TESTPAT_EN adds a 16x16 checkerboard on test_mode.
module hack_vga_scanner #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          H_OFF      = 64,
  parameter int          V_OFF      = 112,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  hack_vga_scanner_if.master        scr,
  input  logic                      test_mode,
  output logic                      hsync,
  output logic                      vsync,
  output logic [3:0]                vga_r,
  output logic [3:0]                vga_g,
  output logic [3:0]                vga_b,
  output logic                      frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] WH_FIRST = 10'(H_OFF);
  localparam logic [9:0] WH_LAST  = 10'(H_OFF + 511);
  localparam logic [9:0] WV_FIRST = 10'(V_OFF);
  localparam logic [9:0] WV_LAST  = 10'(V_OFF + 255);

  // Stage 0 state and derived signals
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [12:0] addr_q, addr_d;
  logic [8:0]  col0;
  logic [7:0]  row0;
  logic        win0, act0, hs0, vs0, fs0;

  // Stage 1 (fetch) registers
  logic        s1_win_q, s1_act_q, s1_hs_q, s1_vs_q, s1_fs_q;
  logic [3:0]  s1_px_q;
  logic [15:0] hold_q, hold_d, word1;
  logic        pix1;

  // Stage 2 (output) registers
  logic        hsync_q, vsync_q, fs_q;
  logic [11:0] rgb_q, rgb_d;

`ifdef HACK_VGA_TESTPAT_EN
  logic        s1_chk_q, s1_tm_q;
`else
  logic        unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Raster counters, window decode and fetch address for the current state
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    col0   = 9'(h_cnt_q - WH_FIRST);
    row0   = 8'(v_cnt_q - WV_FIRST);
    win0   = (h_cnt_q >= WH_FIRST) && (h_cnt_q <= WH_LAST) &&
             (v_cnt_q >= WV_FIRST) && (v_cnt_q <= WV_LAST);
    act0   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs0    = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs0    = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    fs0    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    addr_d = addr_q;
    if (win0 && (col0[3:0] == 4'd0)) addr_d = {row0, col0[8:4]};
  end

  // Stage 0 and stage 1 registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      addr_q   <= '0;
      s1_win_q <= 1'b0;
      s1_act_q <= 1'b0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s1_fs_q  <= 1'b0;
      s1_px_q  <= '0;
      hold_q   <= '0;
`ifdef HACK_VGA_TESTPAT_EN
      s1_chk_q <= 1'b0;
      s1_tm_q  <= 1'b0;
`endif
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      addr_q   <= addr_d;
      s1_win_q <= win0;
      s1_act_q <= act0;
      s1_hs_q  <= hs0;
      s1_vs_q  <= vs0;
      s1_fs_q  <= fs0;
      s1_px_q  <= col0[3:0];
      hold_q   <= hold_d;
`ifdef HACK_VGA_TESTPAT_EN
      s1_chk_q <= col0[4] ^ row0[4];
      s1_tm_q  <= test_mode;
`endif
    end
  end

  // Word select (fresh fetch on the first pixel of a word) and colour decode
  always_comb begin
    word1  = (s1_px_q == 4'd0) ? scr.vga_out : hold_q;
    hold_d = hold_q;
    if (s1_win_q && (s1_px_q == 4'd0)) hold_d = scr.vga_out;
    pix1   = word1[s1_px_q];
`ifdef HACK_VGA_TESTPAT_EN
    if (s1_tm_q) pix1 = s1_chk_q;
`endif
    if (!s1_act_q)      rgb_d = 12'h000;
    else if (!s1_win_q) rgb_d = BORDER_RGB;
    else                rgb_d = pix1 ? 12'h000 : 12'hFFF;
  end

  // Stage 2 output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= s1_hs_q;
      vsync_q <= s1_vs_q;
      fs_q    <= s1_fs_q;
      rgb_q   <= rgb_d;
    end
  end

  assign scr.vga_addr = addr_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_start  = fs_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];

endmodule

// File: tb/tb_hack_vga_scanner.sv
// Bench for hack_vga_scanner with a shortened raster (544x10 total, window
// at column 8 / line 2) so several frames fit in a short run. Expected
// addresses and pixels come from raster arithmetic over a random screen.
module tb_hack_vga_scanner;
  localparam int HA = 528, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 6, VFP = 1, VSY = 2, VBP = 1;
  localparam int HOFF = 8, VOFF = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam logic [11:0] BORDER = 12'h00F;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic test_mode = 1'b0;
  logic hsync, vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;
  logic [15:0] mem [0:8191];

  hack_vga_scanner_if scr_if ();
  assign scr_if.vga_out = mem[scr_if.vga_addr];

  hack_vga_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_OFF(HOFF), .V_OFF(VOFF), .BORDER_RGB(BORDER)
  ) dut (
    .clock(clock), .reset_n(reset_n), .scr(scr_if.master),
    .test_mode(test_mode), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  // clock / reset
  initial forever #5 clock = ~clock;

  logic [27:0] exp_q [$];
  int          n_vec = 0;
  int          n_fail = 0;
  bit          run = 1'b0;
  int          t = 0;
  logic [12:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
    end
  endtask

  function automatic bit in_win(int h, int v);
    return (h >= HOFF) && (h < HOFF + 512) && (v >= VOFF) && (v < VOFF + 256);
  endfunction

  // Reference: {hsync, vsync, frame_start, rgb} for raster position s
  function automatic logic [14:0] model_out(int s);
    int h, v, col, row;
    logic [15:0] w;
    logic px, hs, vs, fs;
    logic [11:0] rgb;
    h  = s % HT;
    v  = (s / HT) % VT;
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    fs = (h == 0) && (v == 0);
    if (h >= HA || v >= VA) rgb = 12'h000;
    else if (in_win(h, v)) begin
      col = h - HOFF;
      row = v - VOFF;
      w   = mem[row * 32 + col / 16];
      px  = w[col % 16];
`ifdef HACK_VGA_TESTPAT_EN
      if (test_mode) px = 1'((col / 16) % 2) ^ 1'((row / 16) % 2);
`endif
      rgb = px ? 12'h000 : 12'hFFF;
    end else rgb = BORDER;
    return {hs, vs, fs, rgb};
  endfunction

  // driver: one expectation per clock edge since reset release
  task automatic run_cycles(input int n);
    int k, h, v;
    logic [14:0] o;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      t = t + 1;
      k = t - 1;
      h = k % HT;
      v = (k / HT) % VT;
      if (in_win(h, v) && ((h - HOFF) % 16 == 0))
        last_addr = 13'((v - VOFF) * 32 + (h - HOFF) / 16);
      if (t >= 2) o = model_out(t - 2);
      else        o = {1'b1, 1'b1, 1'b0, 12'h000};
      exp_q.push_back({last_addr, o});
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, 32'(scr_if.vga_addr), 32'd0);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1;
    reset_n   = 1'b1;
    t         = 0;
    last_addr = '0;
    run       = 1'b1;
  endtask

  // monitor / scoreboard
  initial forever begin
    logic [27:0] e;
    @(negedge clock);
    if (run) begin
      if (exp_q.size() == 0) check("queue_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("vga_addr", 32'(scr_if.vga_addr), 32'(e[27:15]));
        check("hsync", 32'(hsync), 32'(e[14]));
        check("vsync", 32'(vsync), 32'(e[13]));
        check("frame_start", 32'(frame_start), 32'(e[12]));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[11:0]));
      end
    end
  end

  // main sequence
  initial begin
    fill_mem();
    test_mode = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clock);
    check_reset_values("por");
    release_reset();
    run_cycles(2 * HT * VT + 700);
    // asynchronous reset in the middle of a line
    #3;
    run = 1'b0;
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check_reset_values("midline");
    repeat (3) @(negedge clock);
    check_reset_values("held");
    fill_mem();
    test_mode = 1'($urandom_range(0, 1));
    release_reset();
    run_cycles(HT * VT + 100);
    run = 1'b0;
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
